// File: rtl/md_pkg.sv
// md_pkg -- shared definitions for the mult/div sequencer.
//
// Holds the sequencer state encoding, the architectural constants used on
// the exception writeback path (status register and exception codes), and
// the WAIT-cycle limit used when the optional timeout (MD_TIMEOUT_EN) is built.
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;

    localparam int MD_TIMEOUT = 64;
    localparam int TIMEOUT_W  = $clog2(MD_TIMEOUT);

    // Exception code written to the status register for the latched op.
    function automatic logic [31:0] exc_code(input logic isDiv);
        return isDiv ? EXC_DIV : EXC_MULT;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// md_timeout_counter -- counts WAIT cycles of the mult/div sequencer.
//
// Only instantiated when MD_TIMEOUT_EN is defined.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous active-high reset
//   clear_i     in   zero the count (sequencer entering START)
//   count_en_i  in   sequencer is in WAIT this cycle
//   expired_o   out  this WAIT cycle is the MD_TIMEOUT-th one
module md_timeout_counter
    import md_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(MD_TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] ONE        = TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count_q;
    logic [TIMEOUT_W-1:0] count_d;

    // The count holds the number of WAIT cycles already completed, so it
    // reads MD_TIMEOUT-1 during the MD_TIMEOUT-th WAIT cycle. It saturates
    // there because the sequencer always leaves WAIT on that cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != LAST_COUNT)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = count_en_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer -- issues a single mult/div to the multdiv unit, stalls the
// front of the pipeline while it runs, and produces a one-cycle writeback.
//
// Optional feature: define MD_TIMEOUT_EN to abandon an op after MD_TIMEOUT
// WAIT cycles without md_ready; the op then writes back through the
// exception path.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   issue_valid/mult/div         execute stage offers a mult or div
//   issue_a, issue_b, issue_rd   operands and destination of the offered op
//   flush                        abort the in-flight op
//   md_result/exception/ready    response from the multdiv unit
//   ctrl_MULT, ctrl_DIV          one-cycle start pulse to the multdiv unit
//   md_opA, md_opB               latched operands for the multdiv unit
//   stall                        freeze PC/FD, bubble into DX
//   wb_valid, wb_reg, wb_data    one-cycle writeback request
//   busy                         sequencer is not IDLE
module md_sequencer
    import md_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    md_state_t   state_q,  state_d;
    logic [31:0] opA_q,    opA_d;
    logic [31:0] opB_q,    opB_d;
    logic [4:0]  rd_q,     rd_d;
    logic        isDiv_q,  isDiv_d;
    logic [31:0] result_q, result_d;
    logic        exc_q,    exc_d;
    logic        timeoutHit;

`ifdef MD_TIMEOUT_EN
    // Cleared on the edge that enters START so the first WAIT cycle sees 0.
    md_timeout_counter u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clear_i    ((state_q == ST_IDLE) && (state_d == ST_START)),
        .count_en_i (state_q == ST_WAIT),
        .expired_o  (timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    // Next-state logic. An op is captured only from IDLE, so an issue held
    // during a running op is first sampled in the IDLE cycle after DONE.
    // A mult+div request resolves to mult. Flush wins over md_ready and the
    // timeout; a timeout forces the exception writeback.
    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        rd_d     = rd_q;
        isDiv_d  = isDiv_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_valid && (issue_mult || issue_div)) begin
                    state_d = ST_START;
                    opA_d   = issue_a;
                    opB_d   = issue_b;
                    rd_d    = issue_rd;
                    isDiv_d = !issue_mult;
                end
            end
            ST_START: begin
                state_d = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (md_ready) begin
                    state_d  = ST_DONE;
                    result_d = md_result;
                    exc_d    = md_exception;
                end else if (timeoutHit) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            rd_q     <= '0;
            isDiv_q  <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            rd_q     <= rd_d;
            isDiv_q  <= isDiv_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // Outputs are decoded from the registered state. The start pulse and
    // the writeback are suppressed in a cycle where flush is asserted so an
    // aborted op never starts the unit or reaches the register file.
    // The writeback is visible in the DONE cycle and is taken by the
    // register file on the edge that ends it, N+2 edges after the issue edge.
    always_comb begin
        ctrl_MULT = (state_q == ST_START) && !isDiv_q && !flush;
        ctrl_DIV  = (state_q == ST_START) &&  isDiv_q && !flush;
        stall     = (state_q == ST_START) || (state_q == ST_WAIT);
        busy      = (state_q != ST_IDLE);
        wb_valid  = (state_q == ST_DONE) && !flush;
        wb_reg    = '0;
        wb_data   = '0;
        if (state_q == ST_DONE) begin
            wb_reg  = exc_q ? RSTATUS_REG : rd_q;
            wb_data = exc_q ? exc_code(isDiv_q) : result_q;
        end
    end

    assign md_opA = opA_q;
    assign md_opB = opB_q;

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer -- self-checking bench for md_sequencer.
//
// The bench plays the role of the multdiv unit and predicts each writeback
// from the architectural rules: the product or quotient on success, or
// register 30 with code 4 (mult) / 5 (div) on exception. Timing is counted
// in edges after the issue edge: cycle 0 is START, cycles 1..N are WAIT with
// md_ready in cycle N, and the writeback is visible in cycle N+1.
// Build with MD_TIMEOUT_EN defined to exercise the timeout.
module tb_md_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_mult;
    logic        issue_div;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    int passCount  = 0;
    int checkCount = 0;

    md_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_mult   (issue_mult),
        .issue_div    (issue_div),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_rd     (issue_rd),
        .flush        (flush),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_opA       (md_opA),
        .md_opB       (md_opB),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .busy         (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs;
        issue_valid  = 1'b0;
        issue_mult   = 1'b0;
        issue_div    = 1'b0;
        issue_a      = '0;
        issue_b      = '0;
        issue_rd     = '0;
        flush        = 1'b0;
        md_result    = '0;
        md_exception = 1'b0;
        md_ready     = 1'b0;
    endtask

    // Issue one op from IDLE and act as the multdiv unit until the
    // sequencer returns to IDLE. md_ready arrives in WAIT cycle n (never if
    // neverReady); optionally also pulses in START, where it must be ignored.
    task automatic runOp(input bit isMult, input bit isDiv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int n, input bit excIn,
                         input bit readyInStart, input bit neverReady,
                         output int multPulses, output int divPulses,
                         output int stallCycles, output int wbPulses,
                         output int wbCycle, output logic [4:0] wbReg,
                         output logic [31:0] wbData,
                         output logic [31:0] opA, output logic [31:0] opB);
        logic [31:0] unitResult;
        bit          effDiv;
        effDiv = isDiv && !isMult;
        if (effDiv) unitResult = (b == 0) ? 32'd0 : a / b;
        else        unitResult = a * b;
        multPulses = 0; divPulses = 0; stallCycles = 0; wbPulses = 0;
        wbCycle = -1; wbReg = '0; wbData = '0; opA = '0; opB = '0;
        issue_valid = 1'b1;
        issue_mult  = isMult;
        issue_div   = isDiv;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        nextCycle();
        issue_valid = 1'b0;
        issue_mult  = 1'b0;
        issue_div   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            md_ready     = !neverReady && ((k == n) || (k == 0 && readyInStart));
            md_exception = (k == n) ? excIn : 1'b0;
            md_result    = (k == n) ? unitResult : 32'hDEAD_BEEF;
            #1;
            if (k == 0) begin
                opA = md_opA;
                opB = md_opB;
            end
            if (ctrl_MULT) multPulses++;
            if (ctrl_DIV)  divPulses++;
            if (stall)     stallCycles++;
            if (wb_valid) begin
                wbPulses++;
                if (wbCycle < 0) begin
                    wbCycle = k;
                    wbReg   = wb_reg;
                    wbData  = wb_data;
                end
            end
            if (!busy && k > 0) break;
            nextCycle();
        end
        md_ready     = 1'b0;
        md_exception = 1'b0;
    endtask

    // Reset dominates a simultaneous issue; every output reads zero.
    task automatic test_reset;
        idleInputs();
        reset       = 1'b1;
        issue_valid = 1'b1;
        issue_mult  = 1'b1;
        issue_a     = 32'h1234_5678;
        md_ready    = 1'b1;
        nextCycle();
        nextCycle();
        checkCount++;
        if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, busy, md_opA, md_opB, wb_reg, wb_data} !== '0)
            $display("[TB] FAIL reset_outputs: got busy=%b stall=%b opA=%h wb_reg=%0d wb_data=%h, need all 0",
                     busy, stall, md_opA, wb_reg, wb_data);
        else passCount++;
        idleInputs();
        reset = 1'b0;
        nextCycle();
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_idle_after: busy=%b need 0", busy);
        else passCount++;
    endtask

    task automatic test_mult_normal;
        int mp, dp, st, wp, wc;
        logic [4:0] r;
        logic [31:0] d, oa, ob;
        runOp(1'b1, 1'b0, 32'd6, 32'd7, 5'd3, 5, 1'b0, 1'b0, 1'b0, mp, dp, st, wp, wc, r, d, oa, ob);
        checkCount++; if (mp !== 1) $display("[TB] FAIL mult_ctrl_pulses: got %0d need 1", mp); else passCount++;
        checkCount++; if (dp !== 0) $display("[TB] FAIL mult_div_pulses: got %0d need 0", dp); else passCount++;
        checkCount++; if (st !== 6) $display("[TB] FAIL mult_stall_cycles: got %0d need 6", st); else passCount++;
        checkCount++; if (wp !== 1) $display("[TB] FAIL mult_wb_pulses: got %0d need 1", wp); else passCount++;
        checkCount++; if (wc !== 6) $display("[TB] FAIL mult_wb_latency: got cycle %0d need 6", wc); else passCount++;
        checkCount++; if (r !== 5'd3) $display("[TB] FAIL mult_wb_reg: got %0d need 3", r); else passCount++;
        checkCount++; if (d !== 32'd42) $display("[TB] FAIL mult_wb_data: got %0d need 42", d); else passCount++;
        checkCount++;
        if (oa !== 32'd6 || ob !== 32'd7) $display("[TB] FAIL mult_operands: got %0d,%0d need 6,7", oa, ob);
        else passCount++;
    endtask

    task automatic test_div_by_zero;
        int mp, dp, st, wp, wc;
        logic [4:0] r;
        logic [31:0] d, oa, ob;
        runOp(1'b0, 1'b1, 32'd9, 32'd0, 5'd12, 4, 1'b1, 1'b1, 1'b0, mp, dp, st, wp, wc, r, d, oa, ob);
        checkCount++; if (dp !== 1 || mp !== 0) $display("[TB] FAIL div_ctrl_pulses: got div=%0d mult=%0d need 1,0", dp, mp); else passCount++;
        checkCount++; if (r !== 5'd30) $display("[TB] FAIL div0_wb_reg: got %0d need 30", r); else passCount++;
        checkCount++; if (d !== 32'd5) $display("[TB] FAIL div0_wb_data: got %0d need 5", d); else passCount++;
        checkCount++; if (wc !== 5) $display("[TB] FAIL div0_wb_latency: got cycle %0d need 5", wc); else passCount++;
    endtask

    // Op-bit decoding and flush while IDLE.
    task automatic test_decode;
        int mp, dp, st, wp, wc, busySeen;
        logic [4:0] r;
        logic [31:0] d, oa, ob;
        busySeen = 0;
        issue_valid = 1'b1;
        issue_a     = 32'd5;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            if (busy || ctrl_MULT || ctrl_DIV) busySeen++;
        end
        idleInputs();
        checkCount++; if (busySeen !== 0) $display("[TB] FAIL no_op_bits_idle: busy in %0d cycles need 0", busySeen); else passCount++;
        runOp(1'b1, 1'b1, 32'd11, 32'd13, 5'd7, 2, 1'b0, 1'b0, 1'b0, mp, dp, st, wp, wc, r, d, oa, ob);
        checkCount++; if (mp !== 1 || dp !== 0) $display("[TB] FAIL both_bits_is_mult: got mult=%0d div=%0d need 1,0", mp, dp); else passCount++;
        checkCount++; if (d !== 32'd143) $display("[TB] FAIL both_bits_data: got %0d need 143", d); else passCount++;
        issue_valid = 1'b1;
        issue_div   = 1'b1;
        issue_a     = 32'd100;
        issue_b     = 32'd4;
        flush       = 1'b1;
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (busy !== 1'b1 || ctrl_DIV !== 1'b1) $display("[TB] FAIL flush_idle_issue: busy=%b ctrl_DIV=%b need 1,1", busy, ctrl_DIV);
        else passCount++;
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        #1;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL flush_start_abort: busy=%b need 0", busy); else passCount++;
    endtask

    task automatic test_flush;
        int pulses, wbSeen, busySeen;
        pulses = 0; wbSeen = 0; busySeen = 0;
        issue_valid = 1'b1;
        issue_mult  = 1'b1;
        issue_a     = 32'd3;
        issue_b     = 32'd3;
        issue_rd    = 5'd9;
        nextCycle();
        idleInputs();
        for (int k = 0; k < 4; k++) begin
            flush = (k == 3);
            #1;
            if (ctrl_MULT || ctrl_DIV) pulses++;
            if (wb_valid) wbSeen++;
            nextCycle();
        end
        flush = 1'b0;
        #1;
        checkCount++;
        if (busy !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL flush_to_idle: busy=%b stall=%b need 0,0", busy, stall);
        else passCount++;
        md_ready  = 1'b1;
        md_result = 32'd9;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            if (wb_valid) wbSeen++;
            if (busy || stall) busySeen++;
        end
        idleInputs();
        checkCount++; if (pulses !== 1) $display("[TB] FAIL flush_ctrl_pulses: got %0d need 1", pulses); else passCount++;
        checkCount++; if (wbSeen !== 0) $display("[TB] FAIL flush_no_wb: wb_valid seen %0d need 0", wbSeen); else passCount++;
        checkCount++; if (busySeen !== 0) $display("[TB] FAIL flush_late_ready: busy seen %0d need 0", busySeen); else passCount++;
    endtask

    // A second op held on the issue lines throughout the first op.
    task automatic test_back_to_back;
        logic [31:0] a1, b1, a2, b2, wbD1, opAHeld, opA2, opB2, wbD2;
        logic [4:0]  rd1, rd2, wbR1, wbR2;
        logic        wbV1, wbV2, idleGap, start2Div, start2Mult, idleEnd;
        int          pulses;
        a1 = $urandom; b1 = $urandom; rd1 = 5'd4;
        a2 = $urandom; b2 = $urandom_range(1, 1000); rd2 = 5'd21;
        pulses = 0;
        wbV1 = 1'b0; wbR1 = '0; wbD1 = '0; opAHeld = '0; idleGap = 1'b1;
        issue_valid = 1'b1; issue_mult = 1'b1; issue_a = a1; issue_b = b1; issue_rd = rd1;
        nextCycle();
        issue_mult = 1'b0; issue_div = 1'b1; issue_a = a2; issue_b = b2; issue_rd = rd2;
        for (int k = 0; k <= 5; k++) begin
            md_ready  = (k == 3);
            md_result = a1 * b1;
            #1;
            if (k > 0 && (ctrl_MULT || ctrl_DIV)) pulses++;
            if (k == 4) begin
                wbV1 = wb_valid; wbR1 = wb_reg; wbD1 = wb_data; opAHeld = md_opA;
            end
            if (k == 5) idleGap = busy;
            nextCycle();
        end
        md_ready = 1'b0;
        #1;
        start2Div = ctrl_DIV; start2Mult = ctrl_MULT; opA2 = md_opA; opB2 = md_opB;
        issue_valid = 1'b0; issue_div = 1'b0;
        nextCycle();
        md_ready  = 1'b1;
        md_result = a2 / b2;
        nextCycle();
        md_ready = 1'b0;
        #1;
        wbV2 = wb_valid; wbR2 = wb_reg; wbD2 = wb_data;
        nextCycle();
        idleEnd = busy;
        idleInputs();
        checkCount++; if (pulses !== 0) $display("[TB] FAIL b2b_no_early_pulse: got %0d need 0", pulses); else passCount++;
        checkCount++;
        if (wbV1 !== 1'b1 || wbR1 !== rd1 || wbD1 !== a1 * b1)
            $display("[TB] FAIL b2b_first_wb: got v=%b reg=%0d data=%h need 1,%0d,%h", wbV1, wbR1, wbD1, rd1, a1 * b1);
        else passCount++;
        checkCount++; if (opAHeld !== a1) $display("[TB] FAIL b2b_opA_held: got %h need %h", opAHeld, a1); else passCount++;
        checkCount++; if (idleGap !== 1'b0) $display("[TB] FAIL b2b_idle_gap: busy=%b need 0", idleGap); else passCount++;
        checkCount++;
        if (start2Div !== 1'b1 || start2Mult !== 1'b0 || opA2 !== a2 || opB2 !== b2)
            $display("[TB] FAIL b2b_second_start: div=%b mult=%b opA=%h opB=%h need 1,0,%h,%h", start2Div, start2Mult, opA2, opB2, a2, b2);
        else passCount++;
        checkCount++;
        if (wbV2 !== 1'b1 || wbR2 !== rd2 || wbD2 !== a2 / b2)
            $display("[TB] FAIL b2b_second_wb: got v=%b reg=%0d data=%h need 1,%0d,%h", wbV2, wbR2, wbD2, rd2, a2 / b2);
        else passCount++;
        checkCount++; if (idleEnd !== 1'b0) $display("[TB] FAIL b2b_end_idle: busy=%b need 0", idleEnd); else passCount++;
    endtask

    task automatic test_reset_mid_wait;
        int mp, dp, st, wp, wc;
        logic [4:0] r;
        logic [31:0] d, oa, ob;
        issue_valid = 1'b1; issue_mult = 1'b1; issue_a = 32'd8; issue_b = 32'd8; issue_rd = 5'd2;
        nextCycle();
        idleInputs();
        nextCycle();
        nextCycle();
        reset       = 1'b1;
        md_ready    = 1'b1;
        md_result   = 32'd64;
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_div   = 1'b1;
        nextCycle();
        checkCount++;
        if ({ctrl_MULT, ctrl_DIV, stall, wb_valid, busy, md_opA, md_opB, wb_reg, wb_data} !== '0)
            $display("[TB] FAIL reset_mid_wait: got busy=%b stall=%b wb_valid=%b opA=%h, need all 0", busy, stall, wb_valid, md_opA);
        else passCount++;
        reset = 1'b0;
        idleInputs();
        nextCycle();
        runOp(1'b1, 1'b0, 32'd12, 32'd10, 5'd17, 3, 1'b0, 1'b0, 1'b0, mp, dp, st, wp, wc, r, d, oa, ob);
        checkCount++;
        if (r !== 5'd17 || d !== 32'd120 || wc !== 4)
            $display("[TB] FAIL after_reset_mult: got reg=%0d data=%0d cycle=%0d need 17,120,4", r, d, wc);
        else passCount++;
    endtask

`ifdef MD_TIMEOUT_EN
    task automatic test_timeout;
        int mp, dp, st, wp, wc;
        logic [4:0] r;
        logic [31:0] d, oa, ob;
        runOp(1'b1, 1'b0, 32'd2, 32'd3, 5'd5, 0, 1'b0, 1'b0, 1'b1, mp, dp, st, wp, wc, r, d, oa, ob);
        checkCount++; if (wc !== 65) $display("[TB] FAIL timeout_latency: got cycle %0d need 65", wc); else passCount++;
        checkCount++; if (st !== 65) $display("[TB] FAIL timeout_stall: got %0d need 65", st); else passCount++;
        checkCount++;
        if (r !== 5'd30 || d !== 32'd4) $display("[TB] FAIL timeout_wb: got reg=%0d data=%0d need 30,4", r, d);
        else passCount++;
    endtask
`else
    // Without the timeout, WAIT persists indefinitely until flushed.
    task automatic test_timeout;
        int idleSeen;
        idleSeen = 0;
        issue_valid = 1'b1; issue_mult = 1'b1; issue_a = 32'd2; issue_b = 32'd3;
        nextCycle();
        idleInputs();
        for (int k = 0; k < 100; k++) begin
            nextCycle();
            if (!busy || !stall || wb_valid) idleSeen++;
        end
        checkCount++; if (idleSeen !== 0) $display("[TB] FAIL wait_persists: left WAIT in %0d cycles need 0", idleSeen); else passCount++;
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        #1;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL wait_flush: busy=%b need 0", busy); else passCount++;
    endtask
`endif

    // Random ops predicted from the writeback rules.
    task automatic test_random;
        int mp, dp, st, wp, wc, n, sel;
        logic [4:0] r, rd, expReg;
        logic [31:0] d, oa, ob, a, b, expData;
        bit isMult, isDiv, effDiv, exc, rdyStart;
        for (int i = 0; i < 24; i++) begin
            sel      = $urandom_range(0, 2);
            isMult   = (sel != 1);
            isDiv    = (sel != 0);
            effDiv   = isDiv && !isMult;
            a        = $urandom;
            b        = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
            rd       = 5'($urandom_range(0, 31));
            n        = $urandom_range(1, 8);
            exc      = (effDiv && b == 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
            rdyStart = $urandom_range(0, 1);
            runOp(isMult, isDiv, a, b, rd, n, exc, rdyStart, 1'b0, mp, dp, st, wp, wc, r, d, oa, ob);
            expReg  = exc ? 5'd30 : rd;
            expData = exc ? (effDiv ? 32'd5 : 32'd4) : (effDiv ? a / b : a * b);
            checkCount++;
            if (mp !== (effDiv ? 0 : 1) || dp !== (effDiv ? 1 : 0))
                $display("[TB] FAIL rand%0d_pulses: got mult=%0d div=%0d need %0d,%0d", i, mp, dp, effDiv ? 0 : 1, effDiv ? 1 : 0);
            else passCount++;
            checkCount++;
            if (st !== n + 1 || wc !== n + 1 || wp !== 1)
                $display("[TB] FAIL rand%0d_timing: got stall=%0d wbcycle=%0d wbpulses=%0d need %0d,%0d,1", i, st, wc, wp, n + 1, n + 1);
            else passCount++;
            checkCount++;
            if (r !== expReg || d !== expData)
                $display("[TB] FAIL rand%0d_wb: got reg=%0d data=%h need %0d,%h", i, r, d, expReg, expData);
            else passCount++;
        end
    endtask

    initial begin
        $display("[TB] md_sequencer bench start");
        test_reset();
        test_mult_normal();
        test_div_by_zero();
        test_decode();
        test_flush();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
